// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbiter feeding a single registered output stage.
// MODE 0 arbitrates round-robin from a rotating pointer; MODE 1 is fixed
// priority with the lowest index winning. One word per cycle when the
// downstream keeps out_ready high; the output register holds under backpressure.
module rr_arb_mux #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              in_valid,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    output logic [N-1:0]              in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(N)-1:0]      out_sel,
    input  logic                      out_ready
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          load;

    // The output register can take a new word when empty or being drained now.
    assign load = ~out_valid | out_ready;

    // Search from ptr upward, wrapping at N; the first valid channel wins.
    // In fixed-priority mode ptr never leaves 0, so this is a lowest-index search.
    always_comb begin : search
        int idx;
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_any && in_valid[SW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = SW'(idx);
            end
        end
    end

    // Handshake: at most one ready bit, only when the output stage can load.
    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_any) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx];
                out_sel   <= grant_idx;
                if (MODE == 0) begin
                    if (grant_idx == SW'(N - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_idx + SW'(1);
                    end
                end else begin
                    ptr <= '0;
                end
            end else begin
                // Nothing to forward: drop valid, keep last data/sel visible.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: a round-robin and a fixed-priority instance share
// stimulus; each is compared against its own behavioural model every cycle.
module tb_rr_arb_mux;

    localparam int N     = 5;
    localparam int WIDTH = 8;
    localparam int SW    = $clog2(N);

    logic                    clk;
    logic                    rst;
    logic [N-1:0]            in_valid;
    logic [N-1:0][WIDTH-1:0] in_data;
    logic                    out_ready;

    logic [N-1:0]     rdy0, rdy1;
    logic             ov0, ov1;
    logic [WIDTH-1:0] od0, od1;
    logic [SW-1:0]    os0, os1;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = round-robin, 1 = fixed priority.
    int m_valid[2];
    int m_data[2];
    int m_sel[2];
    int m_ptr[2];

    rr_arb_mux #(.N(N), .WIDTH(WIDTH), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.N(N), .WIDTH(WIDTH), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Winner by rule: smallest valid index at or above ptr, else smallest valid
    // index overall; fixed priority is simply the smallest valid index.
    function automatic int pick(input int mode, input int ptr, input logic [N-1:0] v);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (lo < 0) lo = i;
                if (mode == 0 && i >= ptr && hi < 0) hi = i;
            end
        end
        return (hi >= 0) ? hi : lo;
    endfunction

    // One clock: check ready before the edge, advance models, check outputs after.
    task automatic cycle();
        logic [N-1:0] er;
        int g;
        bit ld;
        #1;
        for (int m = 0; m < 2; m++) begin
            ld = (m_valid[m] == 0) || out_ready;
            g  = pick(m, m_ptr[m], in_valid);
            er = '0;
            if (!rst && ld && g >= 0) er[g] = 1'b1;
            check($sformatf("in_ready[m%0d]", m), (m == 0) ? rdy0 : rdy1, er);
        end
        check("onehot0", {$onehot0(rdy0), $onehot0(rdy1)}, 2'b11);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            ld = (m_valid[m] == 0) || out_ready;
            g  = pick(m, m_ptr[m], in_valid);
            if (rst) begin
                m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    m_valid[m] = 1;
                    m_data[m]  = int'(in_data[g]);
                    m_sel[m]   = g;
                    m_ptr[m]   = (m == 0) ? (g + 1) % N : 0;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
        @(negedge clk);
        check("out_valid[m0]", ov0, m_valid[0]);
        check("out_data[m0]",  od0, m_data[0]);
        check("out_sel[m0]",   os0, m_sel[0]);
        check("out_valid[m1]", ov1, m_valid[1]);
        check("out_data[m1]",  od1, m_data[1]);
        check("out_sel[m1]",   os1, m_sel[1]);
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) in_data[i] = WIDTH'(10 + i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
        end
        set_default_data();
        in_valid  = '1;
        out_ready = 1'b1;
        rst       = 1'b1;

        // Reset held two cycles with every channel requesting.
        repeat (2) begin
            cycle();
            check("rst_out_valid", {ov0, ov1}, 2'b00);
            check("rst_out_data", od0, 0);
            check("rst_in_ready", rdy0 | rdy1, 0);
        end

        // Round-robin sweep with everything valid.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_sel", os0, i % N);
            check("rr_data", od0, 10 + (i % N));
        end

        // Fixed priority: channel 1 always beats 2 and 4.
        in_valid = 5'b10110;
        repeat (4) begin
            cycle();
            check("fp_sel", os1, 1);
            check("fp_data", od1, 11);
            check("fp_never_2_4", rdy1 & 5'b10100, 0);
        end

        // Backpressure after granting channel 3.
        do_reset();
        in_valid = '1;
        repeat (4) cycle();
        check("bp_first_sel", os0, 3);
        out_ready = 1'b0;
        repeat (4) begin
            cycle();
            check("bp_hold_data", od0, 13);
            check("bp_hold_sel", os0, 3);
            check("bp_hold_valid", ov0, 1);
            check("bp_in_ready", rdy0, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_sel", os0, 4);

        // Wrap from ptr 4 with sparse requests, then drain to empty.
        do_reset();
        in_valid = '1;
        repeat (4) cycle();
        in_valid = 5'b00011;
        cycle();
        check("wrap_sel0", os0, 0);
        cycle();
        check("wrap_sel1", os0, 1);
        in_valid = '0;
        cycle();
        check("drain_valid", ov0, 0);
        check("drain_sel_hold", os0, 1);
        in_valid = '1;
        cycle();
        check("ptr_after_wrap", os0, 2);

        // Reset while a word is held under backpressure.
        do_reset();
        repeat (3) cycle();
        out_ready = 1'b0;
        cycle();
        check("mid_hold_data", od0, 12);
        rst = 1'b1;
        cycle();
        check("mid_rst_valid", ov0, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("post_rst_sel", os0, 0);
        check("post_rst_valid", ov0, 1);

        // Randomized traffic, backpressure, dropped requests and resets.
        repeat (500) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(49) == 0);
            for (int i = 0; i < N; i++) in_data[i] = WIDTH'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
